// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP load/store gate.
// Cause codes follow the privileged-spec mcause encoding.
package pmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_RESP
  } gate_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } mem_size_t;

  typedef struct packed {
    logic       l;
    logic [1:0] rsv;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  function automatic logic [4:0] size_bytes(
    input logic [1:0] sz
  );
    unique case (sz)
      SZ_BYTE: size_bytes = 5'd1;
      SZ_HALF: size_bytes = 5'd2;
      SZ_WORD: size_bytes = 5'd4;
      default: size_bytes = 5'd0;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    unique case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pmp_load_align.sv
// Byte-lane steering: store shift/byte enables and load
// shift with sign or zero extension.
module pmp_load_align
  import pmp_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [4:0]  sh_amt;
  logic [31:0] rd_sh;

  assign sh_amt   = {addr_lo, 3'b000};
  assign wdata_sh = wdata << sh_amt;
  assign rd_sh    = rdata >> sh_amt;

  always_comb begin
    be        = 4'b1111;
    rdata_ext = rd_sh;
    unique case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        rdata_ext = is_unsigned ?
                    {24'd0, rd_sh[7:0]} :
                    {{24{rd_sh[7]}}, rd_sh[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << addr_lo;
        rdata_ext = is_unsigned ?
                    {16'd0, rd_sh[15:0]} :
                    {{16{rd_sh[15]}}, rd_sh[15:0]};
      end
      default: begin
        be        = 4'b1111;
        rdata_ext = rd_sh;
      end
    endcase
  end

endmodule

// File: rtl/pmp_mem_gate.sv
// Single-outstanding LSU gate between PMP checker and data bus.
// Define PMP_FAULT_STATS_EN to add the saturating fault_cnt output.
module pmp_mem_gate
  import pmp_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CHECK_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      priv_mode,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic [XLEN-1:0] pmp_addr,
  output logic [4:0]      pmp_size,
  output logic [1:0]      pmp_priv,
  input  logic [1:0]      pmp_perm,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic [3:0]      rsp_cause,
  output logic [XLEN-1:0] rsp_tval
`ifdef PMP_FAULT_STATS_EN
  ,
  output logic [31:0]     fault_cnt
`endif
);

  gate_state_t     state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      cnt;
  logic            kill;
  logic            rsp_q;
  logic            fault_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] rdata_q;

  logic [3:0]      be_w;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rdata_ext;
  logic            mis;
  logic            perm_ok;
  logic            rsp_fire;
  logic            kill_now;

  pmp_load_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .be          (be_w),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext)
  );

  assign mis      = misaligned(size_q, addr_q[1:0]);
  assign perm_ok  = we_q ? pmp_perm[1] : pmp_perm[0];
  assign kill_now = kill | flush;

  // A flush during RESP still has to swallow the pulse.
  assign rsp_fire  = rsp_q & ~flush;
  assign rsp_valid = rsp_fire;
  assign rsp_fault = rsp_fire & fault_q;
  assign rsp_cause = rsp_fire ? cause_q : '0;
  assign rsp_tval  = rsp_fire ? tval_q : '0;
  assign rsp_rdata = rsp_fire ? rdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      cnt       <= '0;
      kill      <= 1'b0;
      pmp_addr  <= '0;
      pmp_size  <= '0;
      pmp_priv  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      rsp_q     <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= '0;
      tval_q    <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            pmp_addr  <= req_addr;
            pmp_size  <= size_bytes(req_size);
            pmp_priv  <= priv_mode;
            req_ready <= 1'b0;
            cnt       <= '0;
            kill      <= 1'b0;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (flush) begin
            pmp_addr  <= '0;
            pmp_size  <= '0;
            pmp_priv  <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (cnt == 2'(CHECK_CYCLES - 1)) begin
            pmp_addr <= '0;
            pmp_size <= '0;
            pmp_priv <= '0;
            if (mis || !perm_ok) begin
              rsp_q   <= 1'b1;
              fault_q <= 1'b1;
              tval_q  <= addr_q;
              state   <= ST_RESP;
              unique case (1'b1)
                mis && we_q:   cause_q <= CAUSE_ST_MISALIGN;
                mis && !we_q:  cause_q <= CAUSE_LD_MISALIGN;
                !mis && we_q:  cause_q <= CAUSE_ST_ACCESS;
                default:       cause_q <= CAUSE_LD_ACCESS;
              endcase
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= {addr_q[XLEN-1:2], 2'b00};
              mem_wdata <= wdata_sh;
              mem_we    <= we_q;
              mem_be    <= be_w;
              state     <= ST_MEM_REQ;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ST_MEM_REQ: begin
          if (flush) kill <= 1'b1;
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            if (!we_q) begin
              state <= ST_MEM_WAIT;
            end else if (kill_now) begin
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              rsp_q   <= 1'b1;
              fault_q <= 1'b0;
              state   <= ST_RESP;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (flush) kill <= 1'b1;
          if (mem_rvalid) begin
            if (kill_now) begin
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              rsp_q   <= 1'b1;
              fault_q <= 1'b0;
              rdata_q <= rdata_ext;
              state   <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          rsp_q     <= 1'b0;
          fault_q   <= 1'b0;
          cause_q   <= '0;
          tval_q    <= '0;
          rdata_q   <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PMP_FAULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt <= '0;
    end else if (rsp_fire && fault_q && fault_cnt != '1) begin
      fault_cnt <= fault_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pmp_mem_gate.sv
// Directed self-checking bench for pmp_mem_gate.
// Build with +define+PMP_FAULT_STATS_EN to cover the fault counter.
module tb_pmp_mem_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  priv_mode = '0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] pmp_addr;
  logic [4:0]  pmp_size;
  logic [1:0]  pmp_priv;
  logic [1:0]  pmp_perm = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [3:0]  rsp_cause;
  logic [31:0] rsp_tval;
`ifdef PMP_FAULT_STATS_EN
  logic [31:0] fault_cnt;
`endif

  pmp_mem_gate dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .priv_mode    (priv_mode),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .pmp_addr     (pmp_addr),
    .pmp_size     (pmp_size),
    .pmp_priv     (pmp_priv),
    .pmp_perm     (pmp_perm),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .rsp_cause    (rsp_cause),
    .rsp_tval     (rsp_tval)
`ifdef PMP_FAULT_STATS_EN
    ,
    .fault_cnt    (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  int bus_rd = 0;
  logic [31:0] mem_word = '0;

  logic [31:0] c_paddr, c_psize, c_ppriv;
  logic [31:0] c_maddr, c_mwdata, c_mbe, c_mwe;
  logic [31:0] c_rdata, c_fault, c_cause, c_tval;
  int          c_lat;
  logic        c_saw_mem, c_got;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Zero-wait bus model: read data one cycle after accept.
  always @(posedge clk) begin
    if (mem_valid && mem_ready && !mem_we) begin
      #1;
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word;
      bus_rd++;
    end else begin
      #1;
      mem_rvalid = 1'b0;
    end
  end

  always @(negedge clk) if (rsp_valid) rsp_cnt++;

  task automatic run_req(
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic        we,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [1:0]  pv,
    input logic [1:0]  perm,
    input logic [31:0] rd
  );
    req_addr     = a;
    req_wdata    = wd;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    priv_mode    = pv;
    pmp_perm     = perm;
    mem_word     = rd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    c_paddr   = pmp_addr;
    c_psize   = 32'(pmp_size);
    c_ppriv   = 32'(pmp_priv);
    c_saw_mem = 1'b0;
    c_got     = 1'b0;
    c_lat     = 0;
    {c_maddr, c_mwdata, c_mbe, c_mwe} = '0;
    {c_rdata, c_fault, c_cause, c_tval} = '0;
    for (int i = 1; i <= 20 && !c_got; i++) begin
      @(negedge clk);
      if (mem_valid && !c_saw_mem) begin
        c_saw_mem = 1'b1;
        c_maddr   = mem_addr;
        c_mwdata  = mem_wdata;
        c_mbe     = 32'(mem_be);
        c_mwe     = 32'(mem_we);
      end
      if (rsp_valid) begin
        c_got   = 1'b1;
        c_lat   = i;
        c_rdata = rsp_rdata;
        c_fault = 32'(rsp_fault);
        c_cause = 32'(rsp_cause);
        c_tval  = rsp_tval;
      end
    end
    check("rsp_seen", 32'(c_got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int r0;
  int b0;
  logic [31:0] fc0;

  initial begin
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_memv", 32'(mem_valid), 32'd0);
    check("rst_paddr", pmp_addr, 32'd0);
`ifdef PMP_FAULT_STATS_EN
    check("rst_fcnt", fault_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_req(32'h1004, 0, 1'b0, 2'd2, 1'b0, 2'd0, 2'b01, 32'hDEADBEEF);
    check("ldw_paddr", c_paddr, 32'h1004);
    check("ldw_psize", c_psize, 32'd4);
    check("ldw_ppriv", c_ppriv, 32'd0);
    check("ldw_lat", 32'(c_lat), 32'd4);
    check("ldw_rdata", c_rdata, 32'hDEADBEEF);
    check("ldw_fault", c_fault, 32'd0);
    check("ldw_maddr", c_maddr, 32'h1004);
    check("ldw_be", c_mbe, 32'hF);

    run_req(32'h2003, 32'hA5, 1'b1, 2'd0, 1'b0, 2'd3, 2'b11, 0);
    check("stb_ppriv", c_ppriv, 32'd3);
    check("stb_psize", c_psize, 32'd1);
    check("stb_be", c_mbe, 32'h8);
    check("stb_wdata", c_mwdata, 32'hA500_0000);
    check("stb_we", c_mwe, 32'd1);
    check("stb_maddr", c_maddr, 32'h2000);
    check("stb_fault", c_fault, 32'd0);
    check("stb_lat", 32'(c_lat), 32'd3);

    run_req(32'h3000, 32'h1, 1'b1, 2'd2, 1'b0, 2'd0, 2'b01, 0);
    check("sta_nomem", 32'(c_saw_mem), 32'd0);
    check("sta_fault", c_fault, 32'd1);
    check("sta_cause", c_cause, 32'd7);
    check("sta_tval", c_tval, 32'h3000);
    check("sta_lat", 32'(c_lat), 32'd2);

    run_req(32'h1001, 0, 1'b0, 2'd1, 1'b0, 2'd0, 2'b00, 0);
    check("ldh_mis_cause", c_cause, 32'd4);
    check("ldh_mis_tval", c_tval, 32'h1001);
    check("ldh_mis_nomem", 32'(c_saw_mem), 32'd0);

    run_req(32'h2002, 0, 1'b0, 2'd0, 1'b0, 2'd1, 2'b01, 32'h0080_0000);
    check("ldb_sext", c_rdata, 32'hFFFF_FF80);
    check("ldb_be", c_mbe, 32'h4);
    run_req(32'h2002, 0, 1'b0, 2'd0, 1'b1, 2'd1, 2'b01, 32'h0080_0000);
    check("ldbu_zext", c_rdata, 32'h0000_0080);
    run_req(32'h2002, 0, 1'b0, 2'd1, 1'b0, 2'd1, 2'b01, 32'h8001_0000);
    check("ldh_sext", c_rdata, 32'hFFFF_8001);
    check("ldh_be", c_mbe, 32'hC);

    run_req(32'h4000, 0, 1'b0, 2'd2, 1'b0, 2'd0, 2'b10, 0);
    check("lda_cause", c_cause, 32'd5);
    run_req(32'h5002, 32'h1, 1'b1, 2'd2, 1'b0, 2'd0, 2'b11, 0);
    check("stw_mis_cause", c_cause, 32'd6);
    run_req(32'h6000, 0, 1'b0, 2'd3, 1'b0, 2'd0, 2'b11, 0);
    check("sz3_cause", c_cause, 32'd4);

    // Flush together with a request: nothing captured.
    req_addr  = 32'h7000;
    req_we    = 1'b0;
    req_size  = 2'd2;
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    flush = 1'b0;
    check("flreq_ready", 32'(req_ready), 32'd1);
    check("flreq_paddr", pmp_addr, 32'd0);

    // Flush in CHECK.
    r0 = rsp_cnt;
    pmp_perm  = 2'b01;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flchk_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("flchk_norsp", 32'(rsp_cnt - r0), 32'd0);

    // Flush in MEM_WAIT: bus read still completes.
    r0 = rsp_cnt;
    b0 = bus_rd;
    req_addr  = 32'h1008;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flwait_bus", 32'(bus_rd - b0), 32'd1);
    check("flwait_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("flwait_norsp", 32'(rsp_cnt - r0), 32'd0);

`ifdef PMP_FAULT_STATS_EN
    fc0 = fault_cnt;
`else
    fc0 = '0;
`endif
    run_req(32'h8000, 32'h1, 1'b1, 2'd2, 1'b0, 2'd0, 2'b01, 0);
    run_req(32'h8004, 0, 1'b0, 2'd2, 1'b0, 2'd0, 2'b10, 0);
    run_req(32'h8008, 32'h1, 1'b1, 2'd0, 1'b0, 2'd0, 2'b00, 0);
    check("afl3_cause", c_cause, 32'd7);

    // Fault flushed during its RESP cycle.
    r0 = rsp_cnt;
    req_addr  = 32'h9000;
    req_we    = 1'b1;
    req_size  = 2'd2;
    pmp_perm  = 2'b01;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flresp_rspv", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flresp_ready", 32'(req_ready), 32'd1);
    check("flresp_norsp", 32'(rsp_cnt - r0), 32'd0);
`ifdef PMP_FAULT_STATS_EN
    check("fcnt_plus3", fault_cnt - fc0, 32'd3);
`endif

    // Reset while mem_valid is stalled.
    mem_ready = 1'b0;
    req_addr  = 32'hA000;
    req_wdata = 32'h55;
    req_we    = 1'b1;
    req_size  = 2'd2;
    pmp_perm  = 2'b11;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stall_memv", 32'(mem_valid), 32'd1);
    @(posedge clk);
    #1;
    check("stall_hold", 32'(mem_valid), 32'd1);
    check("stall_addr", mem_addr, 32'hA000);
    rst_n = 1'b0;
    #1;
    check("rstm_memv", 32'(mem_valid), 32'd0);
    check("rstm_be", 32'(mem_be), 32'd0);
    check("rstm_ready", 32'(req_ready), 32'd1);
    check("rstm_rspv", 32'(rsp_valid), 32'd0);
`ifdef PMP_FAULT_STATS_EN
    check("rstm_fcnt", fault_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;

    run_req(32'h100C, 0, 1'b0, 2'd2, 1'b0, 2'd0, 2'b01, 32'h1234_5678);
    check("post_rst_rdata", c_rdata, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
